// File: rtl/pkg_jogo.sv
// Shared definitions for the game: FSM state encoding, default key count and a one-hot check.
// The control unit display decode also uses these.
package pkg_jogo;

   localparam int unsigned N_CHAVES_PADRAO = 4;

   typedef enum logic [2:0] {
      OCIOSO        = 3'd0,
      ESTABILIZA    = 3'd1,
      REGISTRA      = 3'd2,
      INVALIDA      = 3'd3,
      ESPERA_SOLTAR = 3'd4
   } estado_t;

   // True when exactly one bit is set
   function automatic logic eh_one_hot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer of parameterized width with asynchronous active-low clear.
module sincronizador #(
   parameter int unsigned LARGURA = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [LARGURA-1:0] i_d,
   output logic [LARGURA-1:0] o_q
);

   logic [LARGURA-1:0] r_ff1;
   logic [LARGURA-1:0] r_ff2;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ff1 <= '0;
         r_ff2 <= '0;
      end else begin
         r_ff1 <= i_d;
         r_ff2 <= r_ff1;
      end
   end

   assign o_q = r_ff2;

endmodule

// File: rtl/detector_jogada.sv
// Conditions the raw key switches: synchronize, debounce, one-hot check, and emit a single
// pulse per press, re-arming only after every key has been released and held released.
module detector_jogada
   import pkg_jogo::*;
#(
   parameter int unsigned N_CHAVES        = N_CHAVES_PADRAO,
   parameter int unsigned DEBOUNCE_CICLOS = 50000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                habilita,
   input  logic [N_CHAVES-1:0] chaves,
   output logic                jogada_feita,
   output logic [N_CHAVES-1:0] jogada,
   output logic                jogada_invalida,
   output logic                db_tem_jogada,
   output logic [3:0]          db_estado
);

   localparam int unsigned CW = (DEBOUNCE_CICLOS > 2) ? $clog2(DEBOUNCE_CICLOS) : 1;
   localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);

   logic [N_CHAVES-1:0] w_cs;
   estado_t             r_estado, w_estado_prox;
   logic [N_CHAVES-1:0] r_cand, w_cand_prox;
   logic [CW-1:0]       r_cnt, w_cnt_prox;
   logic [N_CHAVES-1:0] r_jogada, w_jogada_prox;
   logic                w_cs_zero;

   sincronizador #(
      .LARGURA (N_CHAVES)
   ) u_sinc (
      .clock (clock),
      .reset (reset),
      .i_d   (chaves),
      .o_q   (w_cs)
   );

   assign w_cs_zero = (w_cs == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_estado <= OCIOSO;
         r_cand   <= '0;
         r_cnt    <= '0;
         r_jogada <= '0;
      end else begin
         r_estado <= w_estado_prox;
         r_cand   <= w_cand_prox;
         r_cnt    <= w_cnt_prox;
         r_jogada <= w_jogada_prox;
      end
   end

   always_comb begin
      w_estado_prox = r_estado;
      w_cand_prox   = r_cand;
      w_cnt_prox    = r_cnt;
      w_jogada_prox = r_jogada;
      case (r_estado)
         OCIOSO: begin
            if (!w_cs_zero && habilita) begin
               w_cand_prox   = w_cs;
               w_cnt_prox    = '0;
               w_estado_prox = ESTABILIZA;
            end
         end
         ESTABILIZA: begin
            // Losing habilita wins over a debounce completing in the same cycle
            if (!habilita) begin
               w_cnt_prox    = '0;
               w_estado_prox = ESPERA_SOLTAR;
            end else if (w_cs_zero) begin
               w_estado_prox = OCIOSO;
            end else if (w_cs != r_cand) begin
               w_cand_prox = w_cs;
               w_cnt_prox  = '0;
            end else if (r_cnt == CNT_FIM) begin
               if (eh_one_hot(32'(r_cand))) begin
                  w_jogada_prox = r_cand;
                  w_estado_prox = REGISTRA;
               end else begin
                  w_estado_prox = INVALIDA;
               end
            end else begin
               w_cnt_prox = r_cnt + 1'b1;
            end
         end
         REGISTRA, INVALIDA: begin
            w_cnt_prox    = '0;
            w_estado_prox = ESPERA_SOLTAR;
         end
         ESPERA_SOLTAR: begin
            if (!w_cs_zero) begin
               w_cnt_prox = '0;
            end else if (r_cnt == CNT_FIM) begin
               w_estado_prox = OCIOSO;
            end else begin
               w_cnt_prox = r_cnt + 1'b1;
            end
         end
         default: begin
            w_cnt_prox    = '0;
            w_estado_prox = OCIOSO;
         end
      endcase
   end

   assign jogada_feita    = (r_estado == REGISTRA);
   assign jogada_invalida = (r_estado == INVALIDA);
   assign jogada          = r_jogada;
   assign db_tem_jogada   = !w_cs_zero;
   assign db_estado       = {1'b0, r_estado};

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada: directed scenarios followed by randomized key activity,
// compared every cycle against a behavioural model of the key conditioner.
module tb_detector_jogada;

   localparam int D = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       habilita = 1'b1;
   logic [3:0] chaves = 4'b0000;
   logic       jogada_feita;
   logic [3:0] jogada;
   logic       jogada_invalida;
   logic       db_tem_jogada;
   logic [3:0] db_estado;

   int n_checks = 0;
   int n_errors = 0;
   int n_pulsos = 0;

   // Behavioural model: a two-entry delay line for the synchronizer, a phase number and counters
   int m_sync[2];
   int m_fase;
   int m_cand;
   int m_cnt;
   int m_jog;

   detector_jogada #(
      .N_CHAVES        (4),
      .DEBOUNCE_CICLOS (D)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .habilita        (habilita),
      .chaves          (chaves),
      .jogada_feita    (jogada_feita),
      .jogada          (jogada),
      .jogada_invalida (jogada_invalida),
      .db_tem_jogada   (db_tem_jogada),
      .db_estado       (db_estado)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_sync[0] = 0;
      m_sync[1] = 0;
      m_fase    = 0;
      m_cand    = 0;
      m_cnt     = 0;
      m_jog     = 0;
   endtask

   // Advance the model by one rising edge using the inputs present just before it
   task automatic model_edge();
      int cs;
      if (!reset) begin
         model_clear();
         return;
      end
      cs = m_sync[1];
      case (m_fase)
         0: if (cs != 0 && habilita) begin m_cand = cs; m_cnt = 0; m_fase = 1; end
         1: begin
            if (!habilita) begin m_cnt = 0; m_fase = 4; end
            else if (cs == 0) m_fase = 0;
            else if (cs != m_cand) begin m_cand = cs; m_cnt = 0; end
            else if (m_cnt == D - 1) begin
               if ($countones(m_cand) == 1) begin m_jog = m_cand; m_fase = 2; end
               else m_fase = 3;
            end else m_cnt++;
         end
         2, 3: begin m_cnt = 0; m_fase = 4; end
         4: begin
            if (cs != 0) m_cnt = 0;
            else if (m_cnt == D - 1) m_fase = 0;
            else m_cnt++;
         end
         default: m_fase = 0;
      endcase
      m_sync[1] = m_sync[0];
      m_sync[0] = int'(chaves);
   endtask

   task automatic check_all();
      chk("estado", 32'(db_estado), 32'(m_fase));
      chk("jogada_feita", 32'(jogada_feita), 32'(m_fase == 2));
      chk("jogada_invalida", 32'(jogada_invalida), 32'(m_fase == 3));
      chk("jogada", 32'(jogada), 32'(m_jog));
      chk("db_tem_jogada", 32'(db_tem_jogada), 32'(m_sync[1] != 0));
      if (jogada_feita) n_pulsos++;
   endtask

   task automatic cyc(input logic h, input logic [3:0] c);
      habilita = h;
      chaves   = c;
      @(posedge clock);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic hold(input logic h, input logic [3:0] c, input int n);
      for (int i = 0; i < n; i++) cyc(h, c);
   endtask

   // Reset asserted between edges: outputs must clear without waiting for a clock
   task automatic async_reset();
      #2 reset = 1'b0;
      #1;
      model_clear();
      check_all();
      @(posedge clock);
      #1 reset = 1'b1;
   endtask

   initial begin
      int p0;
      model_clear();
      #1;
      check_all();
      hold(1'b1, 4'b0100, 2);
      reset = 1'b1;

      // Clean press, chaves stable from before the first active edge
      p0 = n_pulsos;
      hold(1'b1, 4'b0100, 20);
      hold(1'b1, 4'b0000, 8);
      chk("clean_one_pulse", 32'(n_pulsos - p0), 32'd1);
      chk("clean_jogada_held", 32'(jogada), 32'h4);

      // Bounce on press and on release
      p0 = n_pulsos;
      for (int i = 0; i < 6; i++) cyc(1'b1, (i % 2 == 0) ? 4'b0001 : 4'b0000);
      hold(1'b1, 4'b0001, 10);
      for (int i = 0; i < 6; i++) cyc(1'b1, (i % 2 == 0) ? 4'b0000 : 4'b0001);
      hold(1'b1, 4'b0000, 8);
      chk("bounce_one_pulse", 32'(n_pulsos - p0), 32'd1);

      // Multi-key: invalid pulse, jogada keeps previous code
      hold(1'b1, 4'b0011, 12);
      hold(1'b1, 4'b0000, 8);
      chk("multikey_keeps", 32'(jogada), 32'h1);

      // Code change mid-debounce
      p0 = n_pulsos;
      hold(1'b1, 4'b0010, 2);
      hold(1'b1, 4'b1000, 12);
      hold(1'b1, 4'b0000, 8);
      chk("change_one_pulse", 32'(n_pulsos - p0), 32'd1);
      chk("change_jogada", 32'(jogada), 32'h8);

      // habilita gating, then habilita dropped during ESTABILIZA
      hold(1'b0, 4'b0100, 8);
      hold(1'b1, 4'b0100, 10);
      hold(1'b1, 4'b0000, 8);
      p0 = n_pulsos;
      hold(1'b1, 4'b0010, 4);
      hold(1'b0, 4'b0010, 6);
      hold(1'b1, 4'b0000, 8);
      chk("drop_hab_no_pulse", 32'(n_pulsos - p0), 32'd0);

      // Asynchronous reset in ESTABILIZA, then a full debounce again
      hold(1'b1, 4'b0001, 4);
      async_reset();
      hold(1'b1, 4'b0001, 12);
      hold(1'b1, 4'b0000, 8);

      // Randomized bursts
      for (int b = 0; b < 120; b++) begin
         logic [3:0] code;
         int         len;
         logic       h;
         case ($urandom_range(0, 3))
            0: code = 4'b0001 << $urandom_range(0, 3);
            1: code = 4'b0000;
            default: code = 4'($urandom_range(0, 15));
         endcase
         len = $urandom_range(1, 10);
         h   = ($urandom_range(0, 7) != 0);
         for (int i = 0; i < len; i++) begin
            if (i < 3 && $urandom_range(0, 3) == 0) cyc(h, 4'b0000);
            else cyc(h, code);
         end
         if ($urandom_range(0, 29) == 0) async_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
